// File: rtl/count_scan_lut.sv
// count_scan_lut: snapshots a bank of spike counters on a weight-change
// request, scans them in index order and streams each count through two
// runtime-programmable lookup tables as valid/ready beats.
module count_scan_lut #(
  parameter int N_IN    = 16,
  parameter int N_START = 16,
  parameter int CNT_W   = 8,
  parameter int W       = 24,
  parameter int IDX_W   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_START-1:0]     start_wch,
  input  logic [CNT_W*N_IN-1:0]  count,
  input  logic                   lut_wr_en,
  input  logic                   lut_wr_sel,
  input  logic [CNT_W-1:0]       lut_wr_addr,
  input  logic [W-1:0]           lut_wr_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
  output logic [W-1:0]           del_w_plus,
  output logic [W-1:0]           del_w_minus,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int DEPTH = 1 << CNT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [IDX_W-1:0]  rd_idx_r;
  logic [CNT_W-1:0]  snap_r [N_IN];
  logic [CNT_W-1:0]  sel_cnt_s;

  logic              s1_valid_r;
  logic [CNT_W-1:0]  s1_cnt_r;
  logic [IDX_W-1:0]  s1_idx_r;

  logic [W-1:0]      plus_lut  [DEPTH];
  logic [W-1:0]      minus_lut [DEPTH];

  logic              start_s;
  logic              advance_s;
  logic              issue_s;
  logic              last_acc_s;

  // The pipeline only moves when the output slot is empty or being taken,
  // so a stalled beat freezes stage 1 and the read index behind it.
  assign start_s    = |start_wch;
  assign advance_s  = ~out_valid | out_ready;
  assign issue_s    = (state_r == SCAN) & advance_s;
  assign last_acc_s = out_valid & out_ready & out_last;

  // Next-state decode for the scan sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_s = SCAN;
        else         state_s = IDLE;
      end
      SCAN: begin
        if (issue_s && (rd_idx_r == LAST_IDX)) state_s = DRAIN;
        else                                  state_s = SCAN;
      end
      DRAIN: begin
        if (last_acc_s) state_s = IDLE;
        else            state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // Select the snapshot entry addressed by the read index.
  always_comb begin
    sel_cnt_s = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (rd_idx_r == IDX_W'(i)) sel_cnt_s = snap_r[i];
    end
  end

  // Sequencer state, read index, snapshot and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      rd_idx_r <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      for (int i = 0; i < N_IN; i++) snap_r[i] <= '0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != IDLE);
      done    <= last_acc_s;
      overrun <= start_s & busy;
      if ((state_r == IDLE) && start_s) begin
        rd_idx_r <= '0;
        for (int i = 0; i < N_IN; i++) snap_r[i] <= count[CNT_W*i +: CNT_W];
      end else if (issue_s) begin
        rd_idx_r <= rd_idx_r + IDX_W'(1);
      end
    end
  end

  // Stage 1: capture the snapshot count and its channel index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_r <= 1'b0;
      s1_cnt_r   <= '0;
      s1_idx_r   <= '0;
    end else if (advance_s) begin
      s1_valid_r <= issue_s;
      if (issue_s) begin
        s1_cnt_r <= sel_cnt_s;
        s1_idx_r <= rd_idx_r;
      end
    end
  end

  // Stage 2: table lookups and the registered output beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_idx     <= '0;
      out_last    <= 1'b0;
      del_w_plus  <= '0;
      del_w_minus <= '0;
    end else if (advance_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_idx     <= s1_idx_r;
        out_last    <= (s1_idx_r == LAST_IDX);
        del_w_plus  <= plus_lut[s1_cnt_r];
        del_w_minus <= minus_lut[s1_cnt_r];
      end
    end
  end

  // Table write port; contents survive reset, a same-edge read sees old data.
  always_ff @(posedge clk) begin
    if (lut_wr_en) begin
      if (lut_wr_sel == 1'b0) plus_lut[lut_wr_addr]  <= lut_wr_data;
      else                    minus_lut[lut_wr_addr] <= lut_wr_data;
    end
  end

endmodule

// File: tb/tb_count_scan_lut.sv
// Bench for count_scan_lut: directed scans plus randomized counts, tables and
// backpressure, checked against a table-lookup model of the expected stream.
module tb_count_scan_lut;

  localparam int N_IN    = 16;
  localparam int N_START = 16;
  localparam int CNT_W   = 8;
  localparam int W       = 24;
  localparam int IDX_W   = 10;
  localparam int DEPTH   = 1 << CNT_W;

  localparam int H_NONE  = 0;
  localparam int H_COUNT = 1;
  localparam int H_OVR   = 2;
  localparam int H_RST   = 3;
  localparam int H_LUT   = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N_START-1:0]    start_wch = '0;
  logic [CNT_W*N_IN-1:0] count = '0;
  logic                  lut_wr_en = 1'b0;
  logic                  lut_wr_sel = 1'b0;
  logic [CNT_W-1:0]      lut_wr_addr = '0;
  logic [W-1:0]          lut_wr_data = '0;
  logic                  out_ready = 1'b0;
  logic                  out_valid;
  logic [IDX_W-1:0]      out_idx;
  logic                  out_last;
  logic [W-1:0]          del_w_plus;
  logic [W-1:0]          del_w_minus;
  logic                  busy;
  logic                  done;
  logic                  overrun;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] m_plus  [DEPTH];
  logic [W-1:0] m_minus [DEPTH];
  int           m_cnt   [N_IN];

  count_scan_lut #(
    .N_IN(N_IN), .N_START(N_START), .CNT_W(CNT_W), .W(W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .start_wch(start_wch), .count(count),
    .lut_wr_en(lut_wr_en), .lut_wr_sel(lut_wr_sel), .lut_wr_addr(lut_wr_addr),
    .lut_wr_data(lut_wr_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last), .del_w_plus(del_w_plus),
    .del_w_minus(del_w_minus), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_last"}, out_last, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_overrun"}, overrun, 1'b0);
    check({tag, "_idx"}, out_idx, '0);
    check({tag, "_plus"}, del_w_plus, '0);
    check({tag, "_minus"}, del_w_minus, '0);
  endtask

  task automatic lut_write(input logic sel, input int addr, input logic [W-1:0] data);
    lut_wr_en   = 1'b1;
    lut_wr_sel  = sel;
    lut_wr_addr = CNT_W'(addr);
    lut_wr_data = data;
    @(posedge clk); #1;
    lut_wr_en = 1'b0;
    if (sel == 1'b0) m_plus[addr] = data;
    else             m_minus[addr] = data;
  endtask

  task automatic set_counts();
    for (int i = 0; i < N_IN; i++) count[CNT_W*i +: CNT_W] = CNT_W'(m_cnt[i]);
  endtask

  // One scan: pulse start, then follow every cycle until done (or a hook aborts).
  // rmode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic do_scan(input int rmode, input int hook, input logic [N_START-1:0] sv);
    logic [W-1:0]     ep [N_IN];
    logic [W-1:0]     em [N_IN];
    int               c, nxt, ov_c;
    bit               stalled, done_exp, acc, r, aborted, fin;
    logic [IDX_W-1:0] h_idx;
    logic [W-1:0]     h_p, h_m;
    logic             h_l;
    for (int i = 0; i < N_IN; i++) begin
      ep[i] = m_plus[m_cnt[i]];
      em[i] = m_minus[m_cnt[i]];
    end
    h_idx = '0; h_p = '0; h_m = '0; h_l = 1'b0;
    start_wch = sv;
    @(posedge clk); #1;
    start_wch = '0;
    c = 0; nxt = 0; ov_c = -100;
    stalled = 1'b0; done_exp = 1'b0; aborted = 1'b0; fin = 1'b0;
    while (!fin && !aborted && c < 400) begin
      if (c == ov_c + 1) start_wch = '0;
      check("done", done, done_exp);
      check("overrun", overrun, (c == ov_c + 1));
      check("busy", busy, !done_exp);
      if (done_exp) begin
        fin = 1'b1;
      end else begin
        if (stalled) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_idx", out_idx, h_idx);
          check("hold_plus", del_w_plus, h_p);
          check("hold_minus", del_w_minus, h_m);
          check("hold_last", out_last, h_l);
        end else if (out_valid) begin
          check("idx", out_idx, nxt);
          check("plus", del_w_plus, ep[nxt]);
          check("minus", del_w_minus, em[nxt]);
          check("last", out_last, (nxt == N_IN - 1));
          if (rmode == 0) check("cadence", c, nxt + 2);
        end
        if (hook == H_COUNT && c == 2) count = '1;
        if (hook == H_OVR && ov_c < 0 && out_valid && nxt == 5) begin
          start_wch = sv;
          ov_c = c;
        end
        // The write lands on the edge that latches beat 1's table read (count 5).
        if (hook == H_LUT && c == 2) begin
          lut_wr_en = 1'b1; lut_wr_sel = 1'b0; lut_wr_addr = 8'h05; lut_wr_data = 24'h123456;
        end
        if (hook == H_LUT && c == 3) begin
          lut_wr_en = 1'b0;
          m_plus[5] = 24'h123456;
        end
        if (hook == H_RST && out_valid && nxt == 7) begin
          rst = 1'b0;
          #1;
          check_reset_outputs("rst_mid");
          repeat (2) @(posedge clk);
          #1;
          check_reset_outputs("rst_hold");
          rst = 1'b1;
          aborted = 1'b1;
        end
        if (!aborted) begin
          case (rmode)
            0:       r = 1'b1;
            1:       r = ((c % 4) == 0) || ((c % 4) == 3);
            default: r = 1'($urandom_range(0, 1));
          endcase
          out_ready = r;
          acc      = out_valid && r;
          stalled  = out_valid && !r;
          h_idx = out_idx; h_p = del_w_plus; h_m = del_w_minus; h_l = out_last;
          done_exp = acc && (nxt == N_IN - 1);
          if (acc) nxt++;
          @(posedge clk); #1;
          c++;
        end
      end
    end
    if (!aborted) begin
      check("beats_accepted", nxt, N_IN);
      check("scan_finished", fin, 1'b1);
    end
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset_hold");
    rst = 1'b1;

    // Program plus[c] = 3c, minus[c] = 0xFFFFFF - c
    for (int a = 0; a < DEPTH; a++) begin
      lut_write(1'b0, a, W'(a * 3));
      lut_write(1'b1, a, 24'hFFFFFF - W'(a));
    end

    // Basic scan with counts 5i, full throughput
    for (int i = 0; i < N_IN; i++) m_cnt[i] = i * 5;
    set_counts();
    do_scan(0, H_NONE, 16'h0008);
    @(posedge clk); #1;
    check("idle_valid", out_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);

    // Backpressure pattern 1,0,0,1
    do_scan(1, H_NONE, 16'h0008);

    // Counts change mid-scan: snapshot must win
    do_scan(0, H_COUNT, 16'h0100);
    set_counts();

    // Start while busy, then start on the cycle right after done
    do_scan(0, H_OVR, 16'h8000);
    do_scan(0, H_NONE, 16'h0001);

    // Reset mid-scan, then a full scan with the tables intact
    do_scan(0, H_RST, 16'h0002);
    @(posedge clk); #1;
    do_scan(0, H_NONE, 16'h0004);

    // Same-edge table write/read, then the new value on the next scan
    do_scan(0, H_LUT, 16'h0010);
    do_scan(0, H_NONE, 16'h0010);

    // Randomized counts, table entries and backpressure
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N_IN; i++) m_cnt[i] = int'($urandom_range(0, DEPTH - 1));
      set_counts();
      for (int j = 0; j < 12; j++) begin
        lut_write(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), W'($urandom));
      end
      do_scan(2, H_NONE, N_START'($urandom_range(1, (1 << N_START) - 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
